// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the boot-time instruction ROM loader.
package inst_rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } ldr_state_e;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned INST_MEM_SIZE = 16;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Word stream in, ROM write/read-enable port out; slave is the loader side.
interface inst_rom_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              rom_re;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, rom_we, rom_waddr, rom_wdata, rom_re
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, rom_we, rom_waddr, rom_wdata, rom_re
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Streams a program into the instruction ROM while holding the core in reset,
// then enables instruction fetch and releases the core.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned       DEPTH     = INST_MEM_SIZE,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  inst_rom_loader_if.slave           bus,
  output logic                       cpu_rst_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH+1)-1:0] word_count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ldr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ovf_q, ovf_d;
  logic              ready;
  logic              xfer;

  // Moore decodes; async reset to IDLE drops these without a clock edge.
  assign ready        = (state_q == S_LOAD) && (cnt_q < DEPTH_C);
  assign xfer         = bus.in_valid && ready;
  assign bus.in_ready = ready;
  assign bus.rom_we   = we_q;
  assign bus.rom_waddr = waddr_q;
  assign bus.rom_wdata = wdata_q;
  assign bus.rom_re   = (state_q == S_RUN);
  assign done_o       = (state_q == S_RUN);
  assign cpu_rst_o    = (state_q != S_RUN);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign overflow_o   = ovf_q;
  assign word_count_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          waddr_d = BASE_ADDR;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          wdata_d = bus.in_data;
          waddr_d = BASE_ADDR + ADDR_W'(cnt_q) * ADDR_W'(WORD_BYTES);
          cnt_d   = cnt_q + 1'b1;
          if (bus.in_last) state_d = S_FLUSH;
        end else if (cnt_q == DEPTH_C && bus.in_valid) begin
          // Source still has words after the ROM is full: program too long.
          state_d = S_ERR;
          ovf_d   = 1'b1;
        end
      end
      S_FLUSH: state_d = S_RUN;
      S_RUN, S_ERR: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          waddr_d = BASE_ADDR;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader against a cycle-level behavioural model.
module tb_inst_rom_loader;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cpu_rst, busy, done, overflow;
  logic [4:0] word_count;

  int n_chk = 0;
  int n_err = 0;

  inst_rom_loader_if #(.ADDR_W(32)) bus ();

  inst_rom_loader #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .bus          (bus.slave),
    .cpu_rst_o    (cpu_rst),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (overflow),
    .word_count_o (word_count)
  );

  always #5 clk = ~clk;

  // Reference model: loader phase plus what the ROM port should show.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_FLUSH = 2, PH_RUN = 3, PH_ERR = 4;
  int          m_ph;
  int          m_cnt;
  logic        m_ovf, m_we;
  logic [31:0] m_addr, m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_cnt = 0; m_ovf = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic check_outputs(input string pfx);
    logic rdy;
    rdy = (m_ph == PH_LOAD) && (m_cnt < DEPTH);
    chk({pfx, "in_ready"}, 32'(bus.in_ready), 32'(rdy));
    chk({pfx, "busy"}, 32'(busy), 32'(m_ph == PH_LOAD || m_ph == PH_FLUSH));
    chk({pfx, "done"}, 32'(done), 32'(m_ph == PH_RUN));
    chk({pfx, "rom_re"}, 32'(bus.rom_re), 32'(m_ph == PH_RUN));
    chk({pfx, "cpu_rst"}, 32'(cpu_rst), 32'(m_ph != PH_RUN));
    chk({pfx, "overflow"}, 32'(overflow), 32'(m_ovf));
    chk({pfx, "word_count"}, 32'(word_count), 32'(m_cnt));
    chk({pfx, "rom_we"}, 32'(bus.rom_we), 32'(m_we));
    chk({pfx, "rom_waddr"}, bus.rom_waddr, m_addr);
    chk({pfx, "rom_wdata"}, bus.rom_wdata, m_data);
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic cyc(input logic st, input logic v, input logic [31:0] d,
                     input logic l, output logic x);
    logic rdy;
    start = st; bus.in_valid = v; bus.in_data = d; bus.in_last = l;
    @(negedge clk);
    check_outputs("");
    rdy  = (m_ph == PH_LOAD) && (m_cnt < DEPTH);
    x    = v && rdy;
    m_we = 1'b0;
    case (m_ph)
      PH_IDLE: if (st) begin m_ph = PH_LOAD; m_cnt = 0; m_addr = 0; end
      PH_LOAD: begin
        if (x) begin
          m_we = 1'b1; m_data = d; m_addr = 32'(4 * m_cnt); m_cnt++;
          if (l) m_ph = PH_FLUSH;
        end else if (m_cnt == DEPTH && v) begin
          m_ph = PH_ERR; m_ovf = 1'b1;
        end
      end
      PH_FLUSH: m_ph = PH_RUN;
      default: if (st) begin m_ph = PH_LOAD; m_cnt = 0; m_addr = 0; m_ovf = 1'b0; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic x;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, x);
  endtask

  task automatic kick();
    logic x;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, x);
  endtask

  // Offer one word until accepted; gap_pct is the chance of idling a cycle.
  task automatic send(input logic [31:0] d, input logic l, input int gap_pct, input bit rnd_start);
    logic x, v, st;
    int   n;
    n = 0;
    do begin
      v  = ($urandom_range(99) >= 32'(gap_pct));
      st = rnd_start && ($urandom_range(9) == 0);
      cyc(st, v, d, l, x);
      n++;
    end while (!x && n < 50);
    if (!x) chk("send_timeout", 32'(x), 32'd1);
  endtask

  logic [31:0] prog [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};

  initial begin
    logic x;
    int   len;
    rst = 1'b1; start = 0; bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0;
    model_reset();
    #2;
    check_outputs("por_");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Directed three-instruction program, back-to-back.
    kick();
    for (int i = 0; i < 3; i++) send(prog[i], i == 2, 0, 1'b0);
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_not_done", 32'(done), 32'd0);
    chk("last_waddr3", bus.rom_waddr, 32'h8);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, x);  // start in FLUSH is ignored
    chk("done_2edges", 32'(done), 32'd1);
    chk("cpu_released", 32'(cpu_rst), 32'd0);
    chk("wc3", 32'(word_count), 32'd3);
    idle(2);

    // Restart from RUN; words offered on alternate cycles only.
    kick();
    chk("rerun_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rerun_rom_re", 32'(bus.rom_re), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, x);
      send($urandom, i == 4, 0, 1'b0);
    end
    idle(3);

    // Overflow: full ROM without in_last, then the source keeps pushing.
    kick();
    for (int i = 0; i < DEPTH; i++) send($urandom, 1'b0, 30, 1'b1);
    chk("full_not_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, x);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cpu_held", 32'(cpu_rst), 32'd1);
    kick();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) send($urandom, i == 3, 20, 1'b0);
    idle(3);

    // Exactly DEPTH words with in_last on the final one.
    kick();
    for (int i = 0; i < DEPTH; i++) send($urandom, i == DEPTH - 1, 25, 1'b0);
    chk("full_last_addr", bus.rom_waddr, 32'h3C);
    chk("full_last_we", 32'(bus.rom_we), 32'd1);
    idle(2);
    chk("full_run_done", 32'(done), 32'd1);
    chk("full_no_ovf", 32'(overflow), 32'd0);

    // Async reset mid-load, observed before any clock edge.
    kick();
    send($urandom, 1'b0, 0, 1'b0);
    send($urandom, 1'b0, 0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outputs("arst_");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    kick();
    send(32'hDEADBEEF, 1'b0, 0, 1'b0);
    chk("arst_restart_addr", bus.rom_waddr, 32'h0);
    send(32'hCAFEF00D, 1'b1, 0, 1'b0);
    idle(3);

    // Random-length programs with random gaps and stray starts.
    for (int r = 0; r < 8; r++) begin
      kick();
      idle($urandom_range(2));
      len = $urandom_range(DEPTH, 1);
      for (int i = 0; i < len; i++) send($urandom, i == len - 1, 40, 1'b1);
      idle(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Boot-load controller that sequences writes into the instruction ROM's write port from a 32-bit valid/ready word stream (test bench or host link).
- Holds the CPU in reset while loading.
- When loading ends, enables CPU instruction reads and releases the CPU.
- Sits between the program source, the instruction ROM write/read-enable pins and the core's reset input.

Parameters:
- DEPTH, 16, number of 32-bit words the ROM holds; maximum program length.
- ADDR_W, 32, width of the ROM byte address output.
- BASE_ADDR, 0, byte address written by the first word; must be 4-byte aligned.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a (re)load.
- in_valid  in  1  stream word present.
- in_data  in  32  instruction word.
- in_last  in  1  qualifies in_data as the final program word.
- in_ready  out  1  loader accepts a word this cycle.
- rom_we  out  1  ROM write enable.
- rom_waddr  out  ADDR_W  ROM byte address; increments by 4 per word.
- rom_wdata  out  32  ROM write data.
- rom_re  out  1  ROM CPU read enable.
- cpu_rst  out  1  holds the core in reset; active-high.
- busy  out  1  load in progress.
- done  out  1  program loaded, CPU running.
- overflow  out  1  sticky error: DEPTH words accepted without in_last.
- word_count  out  $clog2(DEPTH+1)  words written in the current load.

Behaviour:
- States: IDLE, LOAD, FLUSH, RUN, ERR. Encoding binary, held in a registered state.
- Reset (async, any state, including mid-load) forces:
  - state=IDLE
  - rom_we=0, rom_waddr=BASE_ADDR, rom_wdata=0
  - word_count=0, overflow=0
  - cpu_rst=1, rom_re=0, in_ready=0, busy=0, done=0
- Moore decodes from state only:
  - in_ready=1 only in LOAD with word_count<DEPTH.
  - busy=1 in LOAD and FLUSH.
  - done=1 and rom_re=1 only in RUN.
  - cpu_rst=0 only in RUN.
- IDLE: start moves to LOAD next edge, clearing word_count and rom_waddr. Stream input is ignored.
- LOAD handshake: a transfer occurs when in_valid&in_ready. The write is registered, one cycle latency:
  - at edge N+1, rom_we=1 with the accepted word and its address;
  - rom_waddr=BASE_ADDR+4*(index);
  - word_count increments at the same edge.
  - rom_we deasserts on any cycle without a transfer.
- in_last on a transfer moves LOAD to FLUSH at the same edge as the write pulse. FLUSH unconditionally moves to RUN the following edge. The CPU is therefore released two edges after the last handshake, after the final write has landed.
- Overflow: the DEPTH-th word is accepted without in_last. Then word_count=DEPTH and in_ready=0. If in_valid is seen next cycle, or any cycle thereafter in LOAD, the next edge moves to ERR with overflow=1. The CPU is never released from ERR.
- The DEPTH-th word accepted with in_last follows the normal path to FLUSH/RUN, with no overflow.
- start in LOAD or FLUSH is ignored.
- start in RUN or ERR restarts: next edge enters LOAD, clears counters and overflow, and reasserts cpu_rst.
- Zero-length load (start, then no words) stays in LOAD indefinitely; the CPU remains in reset.
- rom_waddr is never wrapped: word_count caps at DEPTH, so addresses stay within BASE_ADDR..BASE_ADDR+4*(DEPTH-1).

Decomposition:
- Shared package holds:
  - the loader state enum (IDLE, LOAD, FLUSH, RUN, ERR);
  - WORD_BYTES=4;
  - INST_MEM_SIZE=16, also used by the ROM.
- No sub-module is needed; one FSM plus counter fits in a single module.

Test Plan:
- Reset, then start, then 3 words 0x00500093, 0x00A00113, 0x002081B3 with in_last on the third:
  - rom_we pulses at addresses 0x0, 0x4, 0x8 with matching data;
  - done=1 and cpu_rst=0 exactly 2 edges after the third handshake;
  - word_count=3.
- Stall and burst:
  - in_valid toggled every other cycle: no rom_we on gap cycles, addresses remain contiguous.
  - back-to-back valid: one word written per cycle.
- 16 words without in_last, then in_valid held:
  - in_ready drops after the 16th word;
  - state ERR, overflow=1, cpu_rst stays 1.
  - Then start: overflow clears and a fresh load succeeds.
- 16th word with in_last: RUN reached, overflow=0, last write at address 0x3C.
- rst asserted mid-load after 2 words: all outputs are at reset values immediately, without waiting for a clock edge. start after release restarts at address 0x0.
- start while in RUN: cpu_rst reasserts, rom_re=0 next edge, reload overwrites from BASE_ADDR.
